// File: rtl/hsem_pkg.sv
// hsem_pkg: shared state encoding, AHB response/transfer codes and byte-strobe helper
package hsem_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_WR, ST_RD_REQ, ST_RD_RESP, ST_ERR1, ST_ERR2
    } biu_state_e;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    function automatic logic [3:0] gen_wstrb(input logic [2:0] size, input logic [1:0] lo);
        return size == 3'd0 ? 4'b0001 << lo :
               size == 3'd1 ? 4'b0011 << {lo[1], 1'b0} : 4'b1111;
    endfunction
endpackage

// File: rtl/hsem_biu_decode.sv
// hsem_biu_decode: address range, alignment and size check plus byte-strobe generation
module hsem_biu_decode
    import hsem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    output logic              err,
    output logic [3:0]        wstrb
);
    logic [31:0] idx;
    logic        misaligned;

    always_comb begin
        idx        = 32'(addr[ADDR_W-1:2]);
        misaligned = size > 3'd2 || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
        err        = misaligned || idx >= 32'(NUM_REGS);
        wstrb      = gen_wstrb(size, addr[1:0]);
    end
endmodule

// File: rtl/hsem_ahb_biu_wait.sv
// hsem_ahb_biu_wait: AHB-Lite slave turning address/data phases into regfile strobes
// with register-side wait states, two-cycle ERROR responses and registered read data.
module hsem_ahb_biu_wait
    import hsem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                hsel,
    input  logic                hready,
    input  logic [1:0]          htrans,
    input  logic [2:0]          hsize,
    input  logic                hwrite,
    input  logic [31:0]         haddr,
    input  logic [DATA_W-1:0]   hwdata,
    output logic                hreadyout,
    output logic [1:0]          hresp,
    output logic [DATA_W-1:0]   hrdata,
    output logic                reg_wr_en,
    output logic                reg_rd_en,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic [DATA_W-1:0]   reg_wdata,
    output logic [DATA_W/8-1:0] reg_wstrb,
    input  logic [DATA_W-1:0]   reg_rdata,
    input  logic                reg_ready,
    input  logic                reg_err
);
    biu_state_e          state_q, state_d;
    logic                reg_wr_en_q, reg_wr_en_d;
    logic                reg_rd_en_q, reg_rd_en_d;
    logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_W/8-1:0] reg_wstrb_q, reg_wstrb_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;
    logic                accept, dec_err, reg_fail, rd_ok;
    logic [3:0]          dec_wstrb;
    logic                unused_ok;

    assign unused_ok = &{1'b0, haddr[31:ADDR_W], htrans[0]};

    hsem_biu_decode #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_decode (
        .addr  (haddr[ADDR_W-1:0]),
        .size  (hsize),
        .err   (dec_err),
        .wstrb (dec_wstrb)
    );

    // Ready/response follow reg_ready in the same cycle so writes complete with zero waits.
    always_comb begin
        reg_fail    = (state_q == ST_WR || state_q == ST_RD_REQ) && reg_ready && reg_err;
        rd_ok       = state_q == ST_RD_REQ && reg_ready && !reg_err;
        hreadyout   = state_q == ST_WR ? reg_ready & ~reg_err :
                      !(state_q == ST_RD_REQ || state_q == ST_ERR1);
        hresp       = (state_q == ST_ERR1 || state_q == ST_ERR2 || reg_fail) ? HRESP_ERROR : HRESP_OKAY;
        accept      = hsel && hready && htrans[1] && hreadyout;
        state_d     = accept ? (dec_err ? ST_ERR1 : hwrite ? ST_WR : ST_RD_REQ) :
                      (state_q == ST_ERR1 || reg_fail) ? ST_ERR2 :
                      rd_ok ? ST_RD_RESP :
                      hreadyout ? ST_IDLE : state_q;
        reg_wr_en_d = state_d == ST_WR;
        reg_rd_en_d = state_d == ST_RD_REQ;
        reg_addr_d  = accept ? {haddr[ADDR_W-1:2], 2'b00} : reg_addr_q;
        reg_wstrb_d = accept ? dec_wstrb : reg_wstrb_q;
        hrdata_d    = rd_ok ? reg_rdata : hrdata_q;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            reg_wr_en_q <= 1'b0;
            reg_rd_en_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wstrb_q <= '0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            reg_wr_en_q <= reg_wr_en_d;
            reg_rd_en_q <= reg_rd_en_d;
            reg_addr_q  <= reg_addr_d;
            reg_wstrb_q <= reg_wstrb_d;
            hrdata_q    <= hrdata_d;
        end
    end

    assign reg_wr_en = reg_wr_en_q;
    assign reg_rd_en = reg_rd_en_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wstrb = reg_wstrb_q;
    assign reg_wdata = hwdata;
    assign hrdata    = hrdata_q;
endmodule

// File: tb/tb_hsem_ahb_biu_wait.sv
// tb_hsem_ahb_biu_wait: directed scenarios plus randomized transfers against a regfile/bus model
module tb_hsem_ahb_biu_wait;
    localparam int NUM_REGS = 16;

    logic        hclk = 1'b0, hresetn = 1'b0, hsel = 1'b0, hwrite = 1'b0;
    logic        reg_ready = 1'b0, reg_err = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] haddr = '0, hwdata = '0, reg_rdata = '0;
    logic        hready, hreadyout, reg_wr_en, reg_rd_en;
    logic [1:0]  hresp;
    logic [31:0] hrdata, reg_wdata;
    logic [7:0]  reg_addr;
    logic [3:0]  reg_wstrb;
    int          checks = 0, failures = 0;
    logic [31:0] mem [NUM_REGS];
    logic [31:0] last_rd = '0;

    assign hready = hreadyout;
    always #5 hclk = ~hclk;

    hsem_ahb_biu_wait #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(NUM_REGS)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hready(hready), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata),
        .reg_ready(reg_ready), .reg_err(reg_err)
    );

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_bus;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; reg_ready = 1'b0; reg_err = 1'b0;
    endtask

    task automatic addr_phase(input logic w, input logic [31:0] a, input logic [2:0] s);
        hsel = 1'b1; htrans = 2'b10; hwrite = w; haddr = a; hsize = s;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        checks++; if (hreadyout !== 1'b1) begin failures++; $display("FAIL reset_hreadyout got=%0b exp=1", hreadyout); end
        checks++; if (hresp !== 2'b00) begin failures++; $display("FAIL reset_hresp got=%0b exp=00", hresp); end
        checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", hrdata); end
        checks++; if ({reg_wr_en, reg_rd_en} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {reg_wr_en, reg_rd_en}); end
        checks++; if (reg_addr !== 8'h0 || reg_wstrb !== 4'h0) begin failures++; $display("FAIL reset_addr_wstrb got=%h/%b exp=00/0000", reg_addr, reg_wstrb); end
        hresetn = 1'b1;
        tick;
    endtask

    task automatic test_idle_xfers;
        hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd2;
        tick; #1;
        checks++; if (reg_wr_en !== 1'b0 || hreadyout !== 1'b1) begin failures++; $display("FAIL unselected got wr=%0b rdy=%0b exp wr=0 rdy=1", reg_wr_en, hreadyout); end
        hsel = 1'b1; htrans = 2'b01; hwrite = 1'b0;
        tick; #1;
        checks++; if (reg_rd_en !== 1'b0 || hresp !== 2'b00 || hreadyout !== 1'b1) begin failures++; $display("FAIL busy_xfer got rd=%0b resp=%b rdy=%0b exp 0/00/1", reg_rd_en, hresp, hreadyout); end
        idle_bus;
        tick;
    endtask

    task automatic test_word_write;
        addr_phase(1'b1, 32'h08, 3'd2); #1;
        checks++; if (reg_wr_en !== 1'b0) begin failures++; $display("FAIL ww_accept_strobe got=%0b exp=0", reg_wr_en); end
        tick; idle_bus; hwdata = 32'hDEADBEEF; reg_ready = 1'b1; #1;
        checks++; if (reg_wr_en !== 1'b1) begin failures++; $display("FAIL ww_wr_en got=%0b exp=1", reg_wr_en); end
        checks++; if (reg_addr !== 8'h08 || reg_wstrb !== 4'b1111) begin failures++; $display("FAIL ww_addr_wstrb got=%h/%b exp=08/1111", reg_addr, reg_wstrb); end
        checks++; if (reg_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ww_wdata got=%h exp=deadbeef", reg_wdata); end
        checks++; if (hreadyout !== 1'b1 || hresp !== 2'b00) begin failures++; $display("FAIL ww_resp got rdy=%0b resp=%b exp 1/00", hreadyout, hresp); end
        tick; reg_ready = 1'b0; #1;
        checks++; if (reg_wr_en !== 1'b0) begin failures++; $display("FAIL ww_strobe_drop got=%0b exp=0", reg_wr_en); end
    endtask

    task automatic test_read;
        addr_phase(1'b0, 32'h04, 3'd2);
        tick; idle_bus; reg_ready = 1'b1; reg_rdata = 32'h00000001; #1;
        checks++; if (hreadyout !== 1'b0 || reg_rd_en !== 1'b1 || reg_addr !== 8'h04) begin failures++; $display("FAIL rd_req got rdy=%0b rd=%0b addr=%h exp 0/1/04", hreadyout, reg_rd_en, reg_addr); end
        tick; reg_ready = 1'b0; reg_rdata = 32'hFFFF_FFFF; #1;
        checks++; if (hrdata !== 32'h1 || hreadyout !== 1'b1 || hresp !== 2'b00) begin failures++; $display("FAIL rd_resp got data=%h rdy=%0b resp=%b exp 1/1/00", hrdata, hreadyout, hresp); end
        checks++; if (reg_rd_en !== 1'b0) begin failures++; $display("FAIL rd_strobe_drop got=%0b exp=0", reg_rd_en); end
        last_rd = 32'h1;
        tick;
    endtask

    task automatic test_err_pair(input string name, input logic [31:0] a, input logic [2:0] s);
        addr_phase(1'b1, a, s);
        tick; idle_bus; reg_ready = 1'b1; #1;
        checks++; if (hreadyout !== 1'b0 || hresp !== 2'b01 || reg_wr_en !== 1'b0) begin failures++; $display("FAIL %s_err1 got rdy=%0b resp=%b wr=%0b exp 0/01/0", name, hreadyout, hresp, reg_wr_en); end
        tick; #1;
        checks++; if (hreadyout !== 1'b1 || hresp !== 2'b01 || reg_wr_en !== 1'b0) begin failures++; $display("FAIL %s_err2 got rdy=%0b resp=%b wr=%0b exp 1/01/0", name, hreadyout, hresp, reg_wr_en); end
        tick; reg_ready = 1'b0; #1;
        checks++; if (hresp !== 2'b00 || reg_wr_en !== 1'b0) begin failures++; $display("FAIL %s_after got resp=%b wr=%0b exp 00/0", name, hresp, reg_wr_en); end
    endtask

    task automatic test_byte_half;
        addr_phase(1'b1, 32'h0B, 3'd0);
        tick; idle_bus; hwdata = 32'hAA00_0000; reg_ready = 1'b1; #1;
        checks++; if (reg_wstrb !== 4'b1000 || reg_addr !== 8'h08 || reg_wr_en !== 1'b1) begin failures++; $display("FAIL byte_wr got wstrb=%b addr=%h wr=%0b exp 1000/08/1", reg_wstrb, reg_addr, reg_wr_en); end
        tick; reg_ready = 1'b0;
        test_err_pair("half_misaligned", 32'h03, 3'd1);
        test_err_pair("out_of_range", 32'h40, 3'd2);
    endtask

    task automatic test_wait_err;
        addr_phase(1'b1, 32'h10, 3'd2);
        tick; idle_bus; hwdata = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (reg_wr_en !== 1'b1 || hreadyout !== 1'b0 || hresp !== 2'b00) begin failures++; $display("FAIL wait_c%0d got wr=%0b rdy=%0b resp=%b exp 1/0/00", c, reg_wr_en, hreadyout, hresp); end
            tick;
        end
        reg_ready = 1'b1; reg_err = 1'b1; #1;
        checks++; if (reg_wr_en !== 1'b1 || hreadyout !== 1'b0 || hresp !== 2'b01) begin failures++; $display("FAIL wait_err got wr=%0b rdy=%0b resp=%b exp 1/0/01", reg_wr_en, hreadyout, hresp); end
        tick; reg_ready = 1'b0; reg_err = 1'b0; #1;
        checks++; if (reg_wr_en !== 1'b0 || hreadyout !== 1'b1 || hresp !== 2'b01) begin failures++; $display("FAIL wait_err2 got wr=%0b rdy=%0b resp=%b exp 0/1/01", reg_wr_en, hreadyout, hresp); end
        tick;
    endtask

    task automatic test_back_to_back;
        addr_phase(1'b1, 32'h00, 3'd2);
        tick; hwdata = 32'h1111_2222; reg_ready = 1'b1; addr_phase(1'b0, 32'h04, 3'd2); #1;
        checks++; if (reg_wr_en !== 1'b1 || hreadyout !== 1'b1 || reg_addr !== 8'h00) begin failures++; $display("FAIL b2b_write got wr=%0b rdy=%0b addr=%h exp 1/1/00", reg_wr_en, hreadyout, reg_addr); end
        tick; idle_bus; reg_ready = 1'b1; reg_rdata = 32'hCAFE_0001; #1;
        checks++; if (reg_rd_en !== 1'b1 || reg_wr_en !== 1'b0 || reg_addr !== 8'h04) begin failures++; $display("FAIL b2b_read got rd=%0b wr=%0b addr=%h exp 1/0/04", reg_rd_en, reg_wr_en, reg_addr); end
        tick; reg_ready = 1'b0; #1;
        checks++; if (hrdata !== 32'hCAFE_0001 || hreadyout !== 1'b1) begin failures++; $display("FAIL b2b_rdata got=%h rdy=%0b exp cafe0001/1", hrdata, hreadyout); end
        last_rd = 32'hCAFE_0001;
        tick;
    endtask

    task automatic test_reset_mid;
        addr_phase(1'b0, 32'h0C, 3'd2);
        tick; idle_bus; #1;
        checks++; if (reg_rd_en !== 1'b1) begin failures++; $display("FAIL rstmid_pre got rd=%0b exp=1", reg_rd_en); end
        #2 hresetn = 1'b0; #1;
        checks++; if (reg_rd_en !== 1'b0 || reg_wr_en !== 1'b0 || hreadyout !== 1'b1 || hresp !== 2'b00) begin failures++; $display("FAIL rstmid_ctl got rd=%0b wr=%0b rdy=%0b resp=%b exp 0/0/1/00", reg_rd_en, reg_wr_en, hreadyout, hresp); end
        checks++; if (hrdata !== 32'h0 || reg_addr !== 8'h0 || reg_wstrb !== 4'h0) begin failures++; $display("FAIL rstmid_data got data=%h addr=%h wstrb=%b exp 0/0/0", hrdata, reg_addr, reg_wstrb); end
        @(negedge hclk); hresetn = 1'b1; last_rd = '0;
        tick;
    endtask

    task automatic test_random;
        logic w, rerr, exp_err;
        logic [31:0] a, wd;
        logic [2:0] s;
        logic [3:0] ws;
        int lat, idx, nbytes;
        for (int i = 0; i < NUM_REGS; i++) mem[i] = $urandom;
        for (int n = 0; n < 300; n++) begin
            a = $urandom; a[7:0] = 8'($urandom_range(0, 79));
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1)); wd = $urandom;
            lat = $urandom_range(0, 3); rerr = ($urandom_range(0, 5) == 0);
            idx = (a % 256) / 4;
            nbytes = (s <= 3'd2) ? (1 << s) : 1;
            exp_err = s > 3'd2 || idx >= NUM_REGS || (a % nbytes) != 0;
            ws = 4'(((1 << nbytes) - 1) << (a % 4));
            addr_phase(w, a, s); #1;
            checks++; if ({reg_wr_en, reg_rd_en} !== 2'b00) begin failures++; $display("FAIL rnd%0d_accept got=%b exp=00", n, {reg_wr_en, reg_rd_en}); end
            tick; idle_bus; hwdata = wd;
            if (exp_err) begin
                #1;
                checks++; if (hreadyout !== 1'b0 || hresp !== 2'b01 || {reg_wr_en, reg_rd_en} !== 2'b00) begin failures++; $display("FAIL rnd%0d_err1 a=%h s=%0d got rdy=%0b resp=%b st=%b", n, a, s, hreadyout, hresp, {reg_wr_en, reg_rd_en}); end
                tick; #1;
                checks++; if (hreadyout !== 1'b1 || hresp !== 2'b01 || {reg_wr_en, reg_rd_en} !== 2'b00 || hrdata !== last_rd) begin failures++; $display("FAIL rnd%0d_err2 got rdy=%0b resp=%b data=%h exp 1/01/%h", n, hreadyout, hresp, hrdata, last_rd); end
                tick;
            end else begin
                for (int c = 0; c <= lat; c++) begin
                    reg_ready = (c == lat); reg_err = rerr && (c == lat); reg_rdata = mem[idx]; #1;
                    checks++; if (reg_wr_en !== w || reg_rd_en !== !w || reg_addr !== 8'(idx * 4)) begin failures++; $display("FAIL rnd%0d_strobe c=%0d got wr=%0b rd=%0b addr=%h exp %0b/%0b/%h", n, c, reg_wr_en, reg_rd_en, reg_addr, w, !w, 8'(idx * 4)); end
                    if (w) begin
                        checks++; if (reg_wstrb !== ws || reg_wdata !== wd) begin failures++; $display("FAIL rnd%0d_wdata got %b/%h exp %b/%h", n, reg_wstrb, reg_wdata, ws, wd); end
                    end
                    checks++; if (hreadyout !== (w && c == lat && !rerr) || hresp !== ((c == lat && rerr) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL rnd%0d_resp c=%0d got rdy=%0b resp=%b", n, c, hreadyout, hresp); end
                    if (c == lat && !rerr && w) for (int b = 0; b < 4; b++) if (ws[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
                    if (c == lat && !rerr && !w) last_rd = mem[idx];
                    tick;
                end
                idle_bus; #1;
                if (rerr) begin
                    checks++; if (hreadyout !== 1'b1 || hresp !== 2'b01 || {reg_wr_en, reg_rd_en} !== 2'b00) begin failures++; $display("FAIL rnd%0d_regerr2 got rdy=%0b resp=%b", n, hreadyout, hresp); end
                    tick;
                end else if (!w) begin
                    checks++; if (hrdata !== last_rd || hreadyout !== 1'b1 || hresp !== 2'b00 || reg_rd_en !== 1'b0) begin failures++; $display("FAIL rnd%0d_rdata got=%h rdy=%0b exp %h/1", n, hrdata, hreadyout, last_rd); end
                    tick;
                end
                checks++; if (hrdata !== last_rd) begin failures++; $display("FAIL rnd%0d_hold got=%h exp=%h", n, hrdata, last_rd); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_idle_xfers;
        test_word_write;
        test_read;
        test_byte_half;
        test_wait_err;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
